// File: rtl/if_id_buffer.sv
// if_id_buffer: IF->ID instruction FIFO with flush, head pre-split into immediate fields
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_instr,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic [4:0]                 id_shamt,
  output logic [15:0]                id_imm16,
  output logic                       id_imm_sign,
  output logic [17:0]                id_br_off,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [5:0]    op;
  assign if_ready = count != FULL;
  assign id_valid = count != '0;
  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & id_ready & ~flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wr_ptr]    <= if_pc;
      instr_mem[wr_ptr] <= if_instr;
    end
  // Empty reads as a NOP so decode never sees stale storage
  assign id_pc       = id_valid ? pc_mem[rd_ptr] : '0;
  assign id_instr    = id_valid ? instr_mem[rd_ptr] : '0;
  assign op          = id_instr[31:26];
  assign id_shamt    = id_instr[10:6];
  assign id_imm16    = id_instr[15:0];
  assign id_imm_sign = !(op == 6'h0C || op == 6'h0D || op == 6'h0E);
  assign id_br_off   = {id_instr[15:0], 2'b00};
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer (DEPTH = 2)
module tb_if_id_buffer;
  logic        clk = 0, rst = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic [31:0] if_pc = 0, if_instr = 0;
  logic        if_ready, id_valid, id_imm_sign;
  logic [31:0] id_pc, id_instr;
  logic [4:0]  id_shamt;
  logic [15:0] id_imm16;
  logic [17:0] id_br_off;
  logic [1:0]  count;
  int checks = 0, errors = 0;

  if_id_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_shamt(id_shamt), .id_imm16(id_imm16),
    .id_imm_sign(id_imm_sign), .id_br_off(id_br_off), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12 rst = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset id_valid got %b want 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset if_ready got %b want 1", if_ready); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset count got %0d want 0", count); end
    checks++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset head got %h/%h want 0/0", id_pc, id_instr); end
    checks++; if (id_imm_sign !== 1'b1) begin errors++; $display("FAIL reset imm_sign got %b want 1", id_imm_sign); end
    checks++; if (id_br_off !== 18'h0 || id_imm16 !== 16'h0 || id_shamt !== 5'h0) begin errors++; $display("FAIL reset fields got %h %h %h want 0", id_br_off, id_imm16, id_shamt); end
    step;
    checks++; if (id_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL idle got valid %b count %0d want 0 0", id_valid, count); end
  endtask

  task automatic test_single;
    if_valid = 1; if_pc = 32'h0040_0000; if_instr = 32'h3C01_FFFC;
    step;
    if_valid = 0;
    checks++; if (id_valid !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL single valid/count got %b/%0d want 1/1", id_valid, count); end
    checks++; if (id_pc !== 32'h0040_0000 || id_instr !== 32'h3C01_FFFC) begin errors++; $display("FAIL single head got %h/%h want 00400000/3c01fffc", id_pc, id_instr); end
    checks++; if (id_imm16 !== 16'hFFFC || id_imm_sign !== 1'b1) begin errors++; $display("FAIL single imm got %h/%b want fffc/1", id_imm16, id_imm_sign); end
    checks++; if (id_br_off !== 18'h3FFF0 || id_shamt !== 5'h1F) begin errors++; $display("FAIL single br_off/shamt got %h/%h want 3fff0/1f", id_br_off, id_shamt); end
    if_valid = 1; if_pc = 32'h0040_0004; if_instr = 32'h3421_8000;
    step;
    if_valid = 0; id_ready = 1;
    checks++; if (count !== 2'd2 || if_ready !== 1'b0) begin errors++; $display("FAIL single count2 got %0d rdy %b want 2 0", count, if_ready); end
    step;
    id_ready = 0;
    checks++; if (id_instr !== 32'h3421_8000 || id_imm_sign !== 1'b0 || id_imm16 !== 16'h8000) begin errors++; $display("FAIL ori head got %h sign %b imm %h want 34218000 0 8000", id_instr, id_imm_sign, id_imm16); end
    id_ready = 1;
    step;
    id_ready = 0;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0 || id_imm_sign !== 1'b1) begin errors++; $display("FAIL drain got count %0d valid %b sign %b want 0 0 1", count, id_valid, id_imm_sign); end
  endtask

  task automatic test_full;
    if_valid = 1; if_pc = 32'hA0; if_instr = 32'h0000_00A0;
    step;
    if_pc = 32'hA4; if_instr = 32'h0000_00A4;
    step;
    checks++; if (if_ready !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL full got rdy %b count %0d want 0 2", if_ready, count); end
    if_pc = 32'hA8; if_instr = 32'h0000_00A8; id_ready = 1;
    step;
    checks++; if (count !== 2'd1 || id_pc !== 32'hA4) begin errors++; $display("FAIL full pop got count %0d pc %h want 1 a4", count, id_pc); end
    id_ready = 0;
    step;
    if_valid = 0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full accept got count %0d want 2", count); end
    id_ready = 1;
    step;
    checks++; if (id_pc !== 32'hA8 || id_instr !== 32'h0000_00A8 || count !== 2'd1) begin errors++; $display("FAIL full third got %h/%h count %0d want a8/a8 1", id_pc, id_instr, count); end
    step;
    id_ready = 0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL full drain got count %0d want 0", count); end
  endtask

  task automatic test_stream;
    if_valid = 1; id_ready = 1;
    for (int i = 0; i < 10; i++) begin
      if_pc = 32'h1000 + 32'(4 * i); if_instr = 32'h2000_0000 + 32'(i);
      step;
      checks++; if (count !== 2'd1 || id_pc !== 32'h1000 + 32'(4 * i) || id_instr !== 32'h2000_0000 + 32'(i)) begin errors++; $display("FAIL stream[%0d] got pc %h instr %h count %0d want %h %h 1", i, id_pc, id_instr, count, 32'h1000 + 32'(4 * i), 32'h2000_0000 + 32'(i)); end
    end
    if_valid = 0;
    step;
    id_ready = 0;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL stream drain got count %0d valid %b want 0 0", count, id_valid); end
  endtask

  task automatic test_flush;
    if_valid = 1; if_pc = 32'hB0; if_instr = 32'h0000_00B0;
    step;
    if_pc = 32'hB4; if_instr = 32'h0000_00B4;
    step;
    if_pc = 32'hB8; if_instr = 32'h0000_00B8; flush = 1; id_ready = 1;
    step;
    flush = 0; if_valid = 0; id_ready = 0;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL flush got count %0d valid %b instr %h want 0 0 0", count, id_valid, id_instr); end
    step;
    checks++; if (count !== 2'd0 || if_ready !== 1'b1) begin errors++; $display("FAIL flush after got count %0d rdy %b want 0 1", count, if_ready); end
    if_valid = 1; if_pc = 32'hC0; if_instr = 32'h0000_00C0;
    step;
    if_valid = 0;
    checks++; if (id_pc !== 32'hC0 || count !== 2'd1) begin errors++; $display("FAIL flush resume got pc %h count %0d want c0 1", id_pc, count); end
    id_ready = 1;
    step;
    id_ready = 0;
  endtask

  task automatic test_async_reset;
    if_valid = 1; if_pc = 32'hD0; if_instr = 32'h0000_00D0;
    step;
    if_pc = 32'hD4;
    step;
    if_valid = 0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL areset pre got count %0d want 2", count); end
    #2 rst = 1;
    #1;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL areset got count %0d valid %b rdy %b want 0 0 1", count, id_valid, if_ready); end
    #1 rst = 0;
    step;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL areset after got count %0d valid %b want 0 0", count, id_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_full;
    test_stream;
    test_flush;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Decoupling buffer between instruction fetch (IF) and decode (ID) in the dynamic MIPS pipeline. Holds up to DEPTH fetched instructions with their PCs under a valid/ready handshake on both sides, and supports a single-cycle flush on branch or jump redirect. The head entry is presented to decode already split into the immediate fields the extension units consume: 5-bit shamt, 16-bit immediate with its sign/zero select, and the 18-bit word-aligned branch offset.

## Interface
- DEPTH, 2, number of entries; allowed 2, 4, 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all stored entries and any push this cycle.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  buffer can accept; equals not-full.
- if_pc  in  32  PC of the offered instruction.
- if_instr  in  32  offered instruction word.
- id_valid  out  1  head entry is valid; equals not-empty.
- id_ready  in  1  decode consumes the head this cycle.
- id_pc  out  32  head PC.
- id_instr  out  32  head instruction.
- id_shamt  out  5  id_instr[10:6].
- id_imm16  out  16  id_instr[15:0].
- id_imm_sign  out  1  0 for opcode 0x0C/0x0D/0x0E (andi/ori/xori), otherwise 1.
- id_br_off  out  18  {id_instr[15:0], 2'b00}.
- count  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular buffer of DEPTH {pc, instr} entries with read and write pointers of log2(DEPTH) bits, plus an occupancy counter.
- Push = if_valid & if_ready & ~flush: write the entry at wr_ptr, advance wr_ptr modulo DEPTH.
- Pop = id_valid & id_ready & ~flush: advance rd_ptr modulo DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count == DEPTH): if_ready = 0. A push is refused even if a pop happens in the same cycle. There is no combinational path from id_ready to if_ready.
- Empty (count == 0): id_valid = 0. id_pc, id_instr and all derived fields read as 0 (NOP), so id_imm_sign = 1.
- Flush has priority over push and pop. At the next edge, count = 0, rd_ptr = wr_ptr = 0, and the offered instruction is dropped. if_ready stays not-full during the flush cycle.
- Derived fields are pure combinational slices of the head entry. id_imm_sign is decoded from id_instr[31:26].
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no gap or duplicate.

## Timing
- Reset (asynchronous, immediate) drives:
  - count = 0, pointers = 0
  - id_valid = 0, if_ready = 1
  - id_pc = id_instr = 0, id_shamt = 0, id_imm16 = 0, id_br_off = 0, id_imm_sign = 1
- Storage contents need no reset; outputs are masked to 0 while empty.
- Latency: an entry pushed at edge k is visible on id_* with id_valid = 1 from just after edge k.
- Throughput: one instruction per cycle sustained when DEPTH ≥ 2 and id_ready is held at 1.
- Reset asserted mid-stream clears everything within the same cycle, regardless of clk.
- Deasserting rst resumes operation on the next rising edge.
- Status outputs come from registered state only:
  - if_ready and id_valid are registered-state decodes.
  - count is a registered state value.

## Test plan
- Reset then idle:
  - id_valid = 0, if_ready = 1, count = 0, id_instr = 0, id_imm_sign = 1.
- Single transfer, id_ready = 0:
  - Push pc = 0x00400000, instr = 0x3C01FFFC.
  - Next cycle: id_valid = 1, id_imm16 = 0xFFFC, id_imm_sign = 1, id_br_off = 0x3FFF0, count = 1.
  - Then push ori 0x3421_8000: after the pop, the head shows id_imm_sign = 0, id_imm16 = 0x8000.
- Fill to DEPTH = 2 with id_ready = 0:
  - if_ready = 0 and count = 2.
  - A third if_valid is held; with id_ready = 1 it pops, and the third is accepted only on the following cycle.
- Streaming: if_valid = id_ready = 1 for 10 cycles with an incrementing PC:
  - Output is in order, with no loss or duplication across pointer wrap; count stays at 1.
- Flush with 2 entries held plus a concurrent push:
  - Next cycle: count = 0, id_valid = 0, and the pushed instruction never appears.
- Asynchronous rst pulse between edges while count = 2:
  - count = 0 and id_valid = 0 immediately, before the next clk edge.
